// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: MULT, MULTU, DIV, DIVU.
// One radix-2 step per cycle for WIDTH cycles, one sign-fix cycle, then the
// result is committed to the HI/LO registers and done pulses for one cycle.
// MTHI/MTLO writes are accepted whenever the unit is not busy.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             kill,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement negate of a WIDTH-bit value when en is set.
    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x, input logic en);
        cond_neg_w = en ? (~x + ONE_W) : x;
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value when en is set.
    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x, input logic en);
        cond_neg_2w = en ? (~x + ONE_2W) : x;
    endfunction

    state_t               state_r;
    logic [1:0]           op_r;
    logic                 sign1_r;
    logic                 sign2_r;
    logic [WIDTH-1:0]     opnd_r;      // multiplicand (multiply) or divisor (divide) magnitude
    logic [2*WIDTH-1:0]   acc_r;       // product accumulator; low half is dividend/quotient for divide
    logic [WIDTH:0]       rem_r;       // partial remainder
    logic [CW-1:0]        cnt_r;
    logic [WIDTH-1:0]     hi_r;
    logic [WIDTH-1:0]     lo_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 neg1_s;
    logic                 neg2_s;
    logic [WIDTH-1:0]     mag1_s;
    logic [WIDTH-1:0]     mag2_s;
    logic [WIDTH:0]       mul_sum_s;
    logic [2*WIDTH-1:0]   mul_next_s;
    logic [WIDTH+1:0]     div_shift_s;
    logic                 div_ge_s;
    logic [WIDTH:0]       div_rem_next_s;
    logic [WIDTH-1:0]     div_quo_next_s;
    logic                 div_zero_s;
    logic [2*WIDTH-1:0]   prod_fix_s;
    logic [WIDTH-1:0]     quo_fix_s;
    logic [WIDTH-1:0]     rem_fix_s;

    // Operand magnitudes and sign bits captured on an accepted start; op[0]=0 means signed.
    always_comb begin
        neg1_s = ~op[0] & op1[WIDTH-1];
        neg2_s = ~op[0] & op2[WIDTH-1];
        mag1_s = cond_neg_w(op1, neg1_s);
        mag2_s = cond_neg_w(op2, neg2_s);
    end

    // One shift-add multiply step and one restoring divide step from the current state.
    always_comb begin
        mul_sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                         (acc_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s     = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s    = {rem_r, acc_r[WIDTH-1]};
        div_ge_s       = (div_shift_s >= {2'b00, opnd_r});
        div_rem_next_s = (WIDTH+1)'(div_ge_s ? (div_shift_s - {2'b00, opnd_r}) : div_shift_s);
        div_quo_next_s = {acc_r[WIDTH-2:0], div_ge_s};
    end

    // Sign correction applied in FIX; a zero divisor leaves the quotient all ones
    // and the remainder (the dividend magnitude, re-signed) equal to op1 as issued.
    always_comb begin
        div_zero_s = (opnd_r == {WIDTH{1'b0}});
        prod_fix_s = cond_neg_2w(acc_r, sign1_r ^ sign2_r);
        rem_fix_s  = cond_neg_w(rem_r[WIDTH-1:0], sign1_r);
        if (div_zero_s) begin
            quo_fix_s = {WIDTH{1'b1}};
        end else begin
            quo_fix_s = cond_neg_w(acc_r[WIDTH-1:0], sign1_r ^ sign2_r);
        end
    end

    // Control FSM, iteration datapath and the architectural HI/LO registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
            op_r    <= 2'b00;
            sign1_r <= 1'b0;
            sign2_r <= 1'b0;
            opnd_r  <= {WIDTH{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
            rem_r   <= {(WIDTH+1){1'b0}};
            cnt_r   <= {CW{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (wr_hi) begin
                        hi_r <= wdata;
                    end
                    if (wr_lo) begin
                        lo_r <= wdata;
                    end
                    if (start && !kill) begin
                        state_r <= CALC;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        op_r    <= op;
                        sign1_r <= neg1_s;
                        sign2_r <= neg2_s;
                        cnt_r   <= {CW{1'b0}};
                        rem_r   <= {(WIDTH+1){1'b0}};
                        if (op[1]) begin
                            opnd_r <= mag2_s;
                            acc_r  <= {{WIDTH{1'b0}}, mag1_s};
                        end else begin
                            opnd_r <= mag1_s;
                            acc_r  <= {{WIDTH{1'b0}}, mag2_s};
                        end
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end
                end
                CALC: begin
                    if (kill) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else begin
                        if (op_r[1]) begin
                            acc_r <= {acc_r[2*WIDTH-1:WIDTH], div_quo_next_s};
                            rem_r <= div_rem_next_s;
                        end else begin
                            acc_r <= mul_next_s;
                        end
                        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_STEP) begin
                            state_r <= FIX;
                        end
                    end
                end
                FIX: begin
                    busy_r <= 1'b0;
                    if (kill) begin
                        state_r <= IDLE;
                        done_r  <= 1'b0;
                    end else begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        if (op_r[1]) begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_fix_s;
                        end else begin
                            hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                            lo_r <= prod_fix_s[WIDTH-1:0];
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, expected HI/LO pushed
// into a scoreboard at issue and compared by a monitor on every done pulse.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         kill;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];
    logic [63:0] exp_v;
    string       name_v;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .op1(op1), .op2(op2),
        .kill(kill), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h expected no result", hi, lo);
            end else begin
                exp_v  = exp_q.pop_front();
                name_v = name_q.pop_front();
                chk(name_v, {hi, lo}, exp_v);
            end
        end
    end

    // Called at posedge+1; drives start for exactly one edge, returns in cycle 1 of the op.
    task automatic issue(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] expv, input bit push);
        start = 1'b1;
        op    = o;
        op1   = a;
        op2   = b;
        if (push) begin
            exp_q.push_back(expv);
            name_q.push_back(name);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            chk({name, "_timeout"}, 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [34:1] bvec;
        int          done_at;

        reset_n = 1'b0;
        start = 1'b0; op = 2'b00; op1 = '0; op2 = '0;
        kill = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {30'd0, busy, done, hi, lo}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // MULTU max*max with cycle-accurate busy/done timing.
        issue("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b1);
        bvec = '0;
        done_at = 0;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            bvec[c] = busy;
            if (done && done_at == 0) begin
                done_at = c;
            end
        end
        chk("busy_profile", {30'd0, bvec}, {30'd0, 1'b0, {33{1'b1}}});
        chk("done_latency", 64'(done_at), 64'd34);
        @(posedge clk);
        #1;

        issue("mult_neg3x5", MULT, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 1'b1);
        wait_done("mult_neg3x5");
        issue("mult_neg4xneg5", MULT, 32'hFFFFFFFC, 32'hFFFFFFFB, 64'h00000000_00000014, 1'b1);
        wait_done("mult_neg4xneg5");
        issue("multu_2p31x2", MULTU, 32'h80000000, 32'd2, 64'h00000001_00000000, 1'b1);
        wait_done("multu_2p31x2");
        issue("div_neg7_2", DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b1);
        wait_done("div_neg7_2");
        issue("div_7_neg2", DIV, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b1);
        wait_done("div_7_neg2");
        issue("divu_100_7", DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
        wait_done("divu_100_7");
        issue("divu_big_16", DIVU, 32'hFFFFFFFF, 32'h10, 64'h0000000F_0FFFFFFF, 1'b1);
        wait_done("divu_big_16");
        issue("divu_by_zero", DIVU, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, 1'b1);
        wait_done("divu_by_zero");
        issue("div_neg_by_zero", DIV, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_FFFFFFFF, 1'b1);
        wait_done("div_neg_by_zero");
        issue("div_min_neg1", DIV, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b1);
        wait_done("div_min_neg1");

        // Preload HI, then kill a MULTU at cycle 10; the retry completes normally.
        wr_hi = 1'b1;
        wdata = 32'h11;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        chk("mthi_write", {32'd0, hi}, 64'h11);
        issue("kill_victim", MULTU, 32'd6, 32'd7, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_busy_drop", {63'd0, busy}, 64'd0);
        chk("kill_hi_kept", {32'd0, hi}, 64'h11);
        issue("multu_after_kill", MULTU, 32'd6, 32'd7, 64'h00000000_0000002A, 1'b1);
        wait_done("multu_after_kill");

        // MTLO while busy is ignored; async reset mid-DIV clears everything at once.
        issue("reset_victim", DIV, 32'd100, 32'd7, 64'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        wr_lo = 1'b1;
        wdata = 32'hDEAD;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        chk("mtlo_while_busy", {32'd0, lo}, 64'h2A);
        chk("busy_mid_div", {63'd0, busy}, 64'd1);
        repeat (9) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", {30'd0, busy, done, hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue("divu_post_reset", DIVU, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
        wait_done("divu_post_reset");

        wr_lo = 1'b1;
        wdata = 32'h55;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        chk("mtlo_idle", {hi, lo}, 64'h00000002_00000055);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
